spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
Shares one SPI_Protocol master among NUM_REQ requesters and sequences each transfer. For each transfer the block arbitrates the requesters and latches the winner's slave address, mode and byte. It then drives start/load, the per-slave load strobe and CPOL/CPHA, and counts the SCLK bit cycles including the CPOL=1 skipped edge. At the end it captures data_out_master and returns it to the winner.

Parameters:
NUM_REQ, 3, number of requesters (1..4)
BIT_CYCLES, 2, clk cycles per SCLK bit period
IDLE_GAP, 2, clk cycles of forced idle after each transfer (0 allowed)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
req  in  NUM_REQ  per-requester request level; held until gnt
req_addr  in  2*NUM_REQ  slave address per requester; valid slaves 0..2
req_mode  in  2*NUM_REQ  {CPOL,CPHA} per requester
req_data  in  8*NUM_REQ  byte to send from master per requester
gnt  out  NUM_REQ  one-hot grant, high one cycle
done  out  NUM_REQ  one-hot completion pulse, one cycle
rsp_data  out  8  byte received by master, valid with done
rsp_err  out  1  high with done when address was invalid
spi_start  out  1  start strobe to SPI_Protocol
spi_load  out  1  master data load strobe
spi_slave_load  out  3  one-hot slave load strobe (reset1..reset3)
spi_address  out  2  slave select to SPI_Protocol
spi_cpol  out  1  clock polarity
spi_cpha  out  1  clock phase
spi_data_in_master  out  8  byte presented to master
spi_data_out_master  in  8  byte shifted into master

Behaviour:
- Reset values: all outputs 0. State IDLE, round-robin pointer 0, counters 0. Reset mid-transfer aborts it with no done pulse.
- FSM states: IDLE, START, SKIP, SHIFT, CAPTURE, GAP.
- IDLE, if any req at the edge:
  - Pick the winner round-robin from the pointer.
  - Latch its addr, mode and data; go to START.
  - Set the pointer to winner+1 (mod NUM_REQ).
  - With no req, stay in IDLE.
- START (one cycle):
  - gnt[winner]=1.
  - If addr<=2: spi_start=1, spi_load=1, spi_slave_load[addr]=1. Next state is SKIP if CPOL=1, else SHIFT.
  - If addr==3: no spi strobes; next state CAPTURE with rsp_err.
- SKIP: one cycle, absorbs the CPOL=1 idle-high edge; then SHIFT.
- SHIFT: 8*BIT_CYCLES cycles counted 0..8*BIT_CYCLES-1; then CAPTURE.
- CAPTURE (one cycle):
  - done[winner]=1.
  - rsp_data = spi_data_out_master sampled at the last SHIFT edge, or 0 on error; rsp_err set accordingly.
  - Then GAP, or IDLE if IDLE_GAP=0.
- GAP: IDLE_GAP cycles, then IDLE.
- spi_address, spi_cpol, spi_cpha and spi_data_in_master update at entry to START and hold until the next START (also stable in IDLE).
- rsp_data holds until the next CAPTURE.
- Latency, BIT_CYCLES=2: gnt cycle T, done cycle T+17 for CPOL=0 and T+18 for CPOL=1. Error path: done at T+1.
- Back-to-back: the next gnt comes no earlier than done+IDLE_GAP+2.
- A req dropped before gnt is ignored. req values during a transfer are ignored; arbitration happens only in IDLE.
- A requester must drop req the cycle after gnt. If req is still high in IDLE, it is treated as a new request.

Optional Feature:
SPI_ARB_PRIORITY_EN
- Defined: fixed priority, lowest index wins; pointer unused and held at 0.
- Undefined: round-robin as above.

Test Plan:
- Single mode-0 transfer: req[0], addr 0, mode 00, data 8'b00110110, slave 0 preloaded 8'b01001011. Required: gnt[0] at T, spi_slave_load=3'b001 at T, done[0] at T+17, rsp_data=8'b01001011, rsp_err=0.
- Mode-2 transfer: req[1], addr 2, mode 10, slave 2 data 8'b01001110. Required: SKIP cycle present, spi_slave_load=3'b100, done[1] at T+18, rsp_data=8'b01001110.
- Round-robin: req=3'b111 held, each dropped after its own gnt. Required: grants in order 0,1,2. With req[0] re-raised after its gnt, order 0,1,2,0. Under SPI_ARB_PRIORITY_EN with req[0] re-raised after its gnt, order 0,0,...
- Invalid address: addr 3. Required: no spi_start/spi_load/spi_slave_load pulses, done at T+1, rsp_err=1, rsp_data=0.
- Reset mid-SHIFT: assert reset at cycle T+8. Required: all outputs 0 the next cycle, no done pulse, the next request granted normally with pointer 0.
- Gap timing: two queued requests, IDLE_GAP=2. Required: second gnt exactly 4 cycles after first done.

Source files
------------

// File: rtl/spi_txn_arbiter_if.sv
// ============================================================================
// Module      : spi_txn_arbiter_if
// Description : Requester-side handshake and SPI_Protocol-side strobes that
//               connect to spi_txn_arbiter. The slave modport is the arbiter;
//               the master modport is the requesters plus the SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_txn_arbiter_if #(
  parameter int NUM_REQ = 3
);
  // Requester side
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] req_addr;
  logic [2*NUM_REQ-1:0] req_mode;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           rsp_data;
  logic                 rsp_err;

  // SPI_Protocol side
  logic                 spi_start;
  logic                 spi_load;
  logic [2:0]           spi_slave_load;
  logic [1:0]           spi_address;
  logic                 spi_cpol;
  logic                 spi_cpha;
  logic [7:0]           spi_data_in_master;
  logic [7:0]           spi_data_out_master;

  modport slave (
    input  req, req_addr, req_mode, req_data, spi_data_out_master,
    output gnt, done, rsp_data, rsp_err,
           spi_start, spi_load, spi_slave_load, spi_address,
           spi_cpol, spi_cpha, spi_data_in_master
  );

  modport master (
    output req, req_addr, req_mode, req_data, spi_data_out_master,
    input  gnt, done, rsp_data, rsp_err,
           spi_start, spi_load, spi_slave_load, spi_address,
           spi_cpol, spi_cpha, spi_data_in_master
  );
endinterface

`default_nettype wire

// File: rtl/spi_txn_arbiter.sv
// ============================================================================
// Module      : spi_txn_arbiter
// Description : Shares one SPI_Protocol master among NUM_REQ requesters.
//               Arbitrates in IDLE, latches the winner's address/mode/byte,
//               strobes start/load, counts the SCLK bit cycles (plus one
//               skipped edge for CPOL=1), then returns data_out_master.
//               Optional macro SPI_ARB_PRIORITY_EN selects fixed priority
//               (lowest index wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_txn_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int BIT_CYCLES = 2,
  parameter int IDLE_GAP   = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  spi_txn_arbiter_if.slave bus
);

  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SHIFT_LEN = 8 * BIT_CYCLES;
  localparam int CNT_W     = $clog2(SHIFT_LEN);
  localparam int GAP_W     = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_SKIP    = 3'd2,
    S_SHIFT   = 3'd3,
    S_CAPTURE = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [NUM_REQ-1:0]   r_win_oh;
  logic [CNT_W-1:0]     r_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;

  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [7:0]           r_rsp_data;
  logic                 r_rsp_err;
  logic                 r_spi_start;
  logic                 r_spi_load;
  logic [2:0]           r_spi_slave_load;
  logic [1:0]           r_spi_address;
  logic                 r_spi_cpol;
  logic                 r_spi_cpha;
  logic [7:0]           r_spi_data_in;

  logic                 w_any;
  int                   w_sum;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_win;
  logic [IDX_W-1:0]     w_next_ptr;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [1:0]           w_addr;
  logic [1:0]           w_mode;
  logic [7:0]           w_data;

  // Winner selection; scanning from the far end down lets the nearest
  // requesting index (from the pointer, or from 0) overwrite the others.
  always_comb begin
    w_any = |bus.req;
    w_sum = 0;
    w_idx = '0;
    w_win = '0;
`ifdef SPI_ARB_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = IDX_W'(i);
      if (bus.req[w_idx]) w_win = w_idx;
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = IDX_W'(w_sum);
      if (bus.req[w_idx]) w_win = w_idx;
    end
`endif
    w_next_ptr = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    w_win_oh = '0;
    w_win_oh[w_win] = 1'b1;
    w_addr = bus.req_addr[2*w_win +: 2];
    w_mode = bus.req_mode[2*w_win +: 2];
    w_data = bus.req_data[8*w_win +: 8];
  end

  // Transfer sequencer with registered outputs; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_ptr            <= '0;
      r_win_oh         <= '0;
      r_cnt            <= '0;
      r_gap_cnt        <= '0;
      r_gnt            <= '0;
      r_done           <= '0;
      r_rsp_data       <= '0;
      r_rsp_err        <= 1'b0;
      r_spi_start      <= 1'b0;
      r_spi_load       <= 1'b0;
      r_spi_slave_load <= '0;
      r_spi_address    <= '0;
      r_spi_cpol       <= 1'b0;
      r_spi_cpha       <= 1'b0;
      r_spi_data_in    <= '0;
    end else begin
      r_gnt            <= '0;
      r_done           <= '0;
      r_rsp_err        <= 1'b0;
      r_spi_start      <= 1'b0;
      r_spi_load       <= 1'b0;
      r_spi_slave_load <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt         <= w_win_oh;
            r_win_oh      <= w_win_oh;
            r_spi_address <= w_addr;
            r_spi_cpol    <= w_mode[1];
            r_spi_cpha    <= w_mode[0];
            r_spi_data_in <= w_data;
`ifdef SPI_ARB_PRIORITY_EN
            r_ptr         <= '0;
`else
            r_ptr         <= w_next_ptr;
`endif
            // Slave 3 does not exist: the transfer is granted but never
            // reaches the SPI master.
            if (w_addr != 2'd3) begin
              r_spi_start      <= 1'b1;
              r_spi_load       <= 1'b1;
              r_spi_slave_load <= 3'b001 << w_addr;
            end
            r_state <= S_START;
          end
        end

        S_START: begin
          r_cnt <= '0;
          if (r_spi_address == 2'd3) begin
            r_done     <= r_win_oh;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_CAPTURE;
          end else if (r_spi_cpol) begin
            r_state <= S_SKIP;
          end else begin
            r_state <= S_SHIFT;
          end
        end

        // Absorbs the idle-high SCLK edge that CPOL=1 produces first.
        S_SKIP: r_state <= S_SHIFT;

        S_SHIFT: begin
          if (r_cnt == CNT_W'(SHIFT_LEN - 1)) begin
            r_done     <= r_win_oh;
            r_rsp_data <= bus.spi_data_out_master;
            r_state    <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_CAPTURE: begin
          r_gap_cnt <= '0;
          r_state   <= (IDLE_GAP == 0) ? S_IDLE : S_GAP;
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt                = r_gnt;
  assign bus.done               = r_done;
  assign bus.rsp_data           = r_rsp_data;
  assign bus.rsp_err            = r_rsp_err;
  assign bus.spi_start          = r_spi_start;
  assign bus.spi_load           = r_spi_load;
  assign bus.spi_slave_load     = r_spi_slave_load;
  assign bus.spi_address        = r_spi_address;
  assign bus.spi_cpol           = r_spi_cpol;
  assign bus.spi_cpha           = r_spi_cpha;
  assign bus.spi_data_in_master = r_spi_data_in;

endmodule

`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
// ============================================================================
// Module      : tb_spi_txn_arbiter
// Description : Directed self-checking bench for spi_txn_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_txn_arbiter;

  localparam int NUM_REQ    = 3;
  localparam int BIT_CYCLES = 2;
  localparam int IDLE_GAP   = 2;
  localparam int LAT0       = 8 * BIT_CYCLES + 1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  spi_txn_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  spi_txn_arbiter #(
    .NUM_REQ(NUM_REQ), .BIT_CYCLES(BIT_CYCLES), .IDLE_GAP(IDLE_GAP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int idx, input logic [1:0] addr, input logic [1:0] mode,
                         input logic [7:0] data);
    bus.req_addr[2*idx +: 2] = addr;
    bus.req_mode[2*idx +: 2] = mode;
    bus.req_data[8*idx +: 8] = data;
    bus.req[idx] = 1'b1;
  endtask

  // Runs one transfer from IDLE and records what was observed.
  task automatic run_xfer(input int idx, input logic [1:0] addr, input logic [1:0] mode,
                          input logic [7:0] data, input logic [7:0] sbyte,
                          output logic [2:0] g, output logic [2:0] sl,
                          output logic st, output logic ld, output int later,
                          output int done_at, output logic [2:0] dv,
                          output logic [7:0] rd, output logic re);
    int last;
    last = mode[1] ? LAT0 : LAT0 - 1;
    set_req(idx, addr, mode, data);
    step();
    g = bus.gnt; sl = bus.spi_slave_load; st = bus.spi_start; ld = bus.spi_load;
    bus.req[idx] = 1'b0;
    later = 0; done_at = -1; dv = '0; rd = '0; re = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      bus.spi_data_out_master = (k - 1 == last) ? sbyte : 8'hC3;
      step();
      if (bus.spi_start || bus.spi_load || (bus.spi_slave_load != 3'b000)) later++;
      if ((bus.done != '0) && (done_at < 0)) begin
        done_at = k; dv = bus.done; rd = bus.rsp_data; re = bus.rsp_err;
      end
    end
    bus.spi_data_out_master = 8'hC3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    checks++;
    if ({bus.gnt, bus.done} !== 6'b0) begin
      errors++; $display("FAIL reset_gnt_done: got %b expected 000000", {bus.gnt, bus.done});
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_err} !== 9'b0) begin
      errors++; $display("FAIL reset_rsp: got %h expected 000", {bus.rsp_data, bus.rsp_err});
    end
    checks++;
    if ({bus.spi_start, bus.spi_load, bus.spi_slave_load, bus.spi_address,
         bus.spi_cpol, bus.spi_cpha, bus.spi_data_in_master} !== 17'b0) begin
      errors++; $display("FAIL reset_spi: got %h expected 0", {bus.spi_start, bus.spi_load,
        bus.spi_slave_load, bus.spi_address, bus.spi_cpol, bus.spi_cpha, bus.spi_data_in_master});
    end
  endtask

  task automatic test_mode0();
    logic [2:0] g, sl, dv; logic st, ld, re; int later, done_at; logic [7:0] rd;
    run_xfer(0, 2'd0, 2'b00, 8'b00110110, 8'b01001011, g, sl, st, ld, later, done_at, dv, rd, re);
    checks++;
    if (g !== 3'b001) begin errors++; $display("FAIL m0_gnt: got %b expected 001", g); end
    checks++;
    if ({sl, st, ld} !== 5'b00111) begin
      errors++; $display("FAIL m0_strobes: got %b expected 00111", {sl, st, ld});
    end
    checks++;
    if (done_at !== LAT0) begin errors++; $display("FAIL m0_latency: got %0d expected %0d", done_at, LAT0); end
    checks++;
    if (dv !== 3'b001) begin errors++; $display("FAIL m0_done_vec: got %b expected 001", dv); end
    checks++;
    if ({rd, re} !== {8'b01001011, 1'b0}) begin
      errors++; $display("FAIL m0_rsp: got %h/%b expected 4b/0", rd, re);
    end
    checks++;
    if ({bus.spi_data_in_master, bus.spi_address, bus.spi_cpol} !== {8'h36, 2'd0, 1'b0}) begin
      errors++; $display("FAIL m0_hold: got %h expected 360", {bus.spi_data_in_master, bus.spi_address, bus.spi_cpol});
    end
    checks++;
    if (bus.rsp_data !== 8'b01001011) begin
      errors++; $display("FAIL m0_rsp_hold: got %h expected 4b", bus.rsp_data);
    end
  endtask

  task automatic test_mode2();
    logic [2:0] g, sl, dv; logic st, ld, re; int later, done_at; logic [7:0] rd;
    run_xfer(1, 2'd2, 2'b10, 8'h5A, 8'b01001110, g, sl, st, ld, later, done_at, dv, rd, re);
    checks++;
    if ({g, sl} !== 6'b010100) begin
      errors++; $display("FAIL m2_gnt_sl: got %b expected 010100", {g, sl});
    end
    checks++;
    if (done_at !== LAT0 + 1) begin
      errors++; $display("FAIL m2_latency: got %0d expected %0d", done_at, LAT0 + 1);
    end
    checks++;
    if ({dv, rd} !== {3'b010, 8'b01001110}) begin
      errors++; $display("FAIL m2_rsp: got %b/%h expected 010/4e", dv, rd);
    end
    checks++;
    if ({bus.spi_cpol, bus.spi_cpha, bus.spi_address} !== 4'b1010) begin
      errors++; $display("FAIL m2_mode: got %b expected 1010", {bus.spi_cpol, bus.spi_cpha, bus.spi_address});
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    set_req(0, 2'd0, 2'b00, 8'h36);
    step();
    bus.req[0] = 1'b0;
    checks++;
    if (bus.gnt !== 3'b001) begin errors++; $display("FAIL rm_gnt: got %b expected 001", bus.gnt); end
    repeat (8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.gnt, bus.done, bus.rsp_data, bus.rsp_err, bus.spi_start, bus.spi_load,
         bus.spi_slave_load, bus.spi_address, bus.spi_cpol, bus.spi_cpha,
         bus.spi_data_in_master} !== 32'b0) begin
      errors++; $display("FAIL rm_outputs: got %h expected 0", {bus.gnt, bus.done, bus.rsp_data,
        bus.rsp_err, bus.spi_start, bus.spi_load, bus.spi_slave_load, bus.spi_address,
        bus.spi_cpol, bus.spi_cpha, bus.spi_data_in_master});
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.done != '0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL rm_no_done: got %0d expected 0", pulses); end
    // Pointer before reset was 1, so req 101 distinguishes a cleared pointer.
    set_req(0, 2'd1, 2'b00, 8'h11);
    set_req(2, 2'd1, 2'b00, 8'h22);
    step();
    checks++;
    if (bus.gnt !== 3'b001) begin errors++; $display("FAIL rm_regrant: got %b expected 001", bus.gnt); end
    bus.req = '0;
    repeat (25) step();
  endtask

  task automatic test_invalid();
    logic [2:0] g, sl, dv; logic st, ld, re; int later, done_at; logic [7:0] rd;
    run_xfer(2, 2'd3, 2'b00, 8'hFF, 8'h99, g, sl, st, ld, later, done_at, dv, rd, re);
    checks++;
    if ({g, sl, st, ld} !== 8'b10000000) begin
      errors++; $display("FAIL inv_gnt_strobes: got %b expected 10000000", {g, sl, st, ld});
    end
    checks++;
    if (later !== 0) begin errors++; $display("FAIL inv_late_strobes: got %0d expected 0", later); end
    checks++;
    if (done_at !== 1) begin errors++; $display("FAIL inv_latency: got %0d expected 1", done_at); end
    checks++;
    if ({dv, rd, re} !== {3'b100, 8'h00, 1'b1}) begin
      errors++; $display("FAIL inv_rsp: got %b/%h/%b expected 100/00/1", dv, rd, re);
    end
  endtask

  task automatic test_round_robin();
    int order[4];
    int exp2[4];
    int n;
    logic pend, reraised;
`ifdef SPI_ARB_PRIORITY_EN
    exp2 = '{0, 0, 1, 2};
`else
    exp2 = '{0, 1, 2, 0};
`endif
    set_req(0, 2'd0, 2'b00, 8'h01);
    set_req(1, 2'd3, 2'b00, 8'h02);
    set_req(2, 2'd3, 2'b00, 8'h03);
    n = 0;
    order = '{-1, -1, -1, -1};
    for (int k = 0; k < 200 && n < 3; k++) begin
      step();
      if (bus.gnt != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) begin order[n] = i; bus.req[i] = 1'b0; end
        n++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (order[j] !== j) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", j, order[j], j); end
    end
    repeat (10) step();

    bus.req = 3'b111;
    n = 0; pend = 1'b0; reraised = 1'b0;
    order = '{-1, -1, -1, -1};
    for (int k = 0; k < 300 && n < 4; k++) begin
      step();
      if (pend) begin bus.req[0] = 1'b1; pend = 1'b0; reraised = 1'b1; end
      if (bus.gnt != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) begin order[n] = i; bus.req[i] = 1'b0; end
        if (bus.gnt[0] && !reraised) pend = 1'b1;
        n++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (order[j] !== exp2[j]) begin
        errors++; $display("FAIL rr_rearm[%0d]: got %0d expected %0d", j, order[j], exp2[j]);
      end
    end
    bus.req = '0;
    repeat (25) step();
  endtask

  task automatic test_back_to_back();
    int ng, done1, gnt2;
    set_req(0, 2'd0, 2'b00, 8'hA0);
    set_req(1, 2'd1, 2'b00, 8'hA1);
    ng = 0; done1 = -1; gnt2 = -1;
    for (int k = 0; k < 100 && ng < 2; k++) begin
      step();
      if ((bus.done != '0) && (done1 < 0)) done1 = cyc;
      if (bus.gnt != '0) begin
        ng++;
        if (ng == 2) gnt2 = cyc;
        for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) bus.req[i] = 1'b0;
      end
    end
    checks++;
    if (ng !== 2) begin errors++; $display("FAIL b2b_grants: got %0d expected 2", ng); end
    checks++;
    if (gnt2 - done1 !== IDLE_GAP + 2) begin
      errors++; $display("FAIL b2b_gap: got %0d expected %0d", gnt2 - done1, IDLE_GAP + 2);
    end
    bus.req = '0;
    repeat (25) step();
  endtask

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_mode = '0;
    bus.req_data = '0;
    bus.spi_data_out_master = 8'hC3;
    test_reset();
    test_mode0();
    test_mode2();
    test_reset_mid();
    test_invalid();
    test_round_robin();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
